// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter (shift-add-3) with a valid/ready input,
// a one-cycle result pulse and an out-of-range flag.
module bin2bcd_seq #(
    parameter int unsigned BIN_W   = 6,
    parameter int unsigned DIGITS  = 2,
    parameter int unsigned MAX_VAL = 59
) (
    input  logic                  clk,
    input  logic                  reset_,
    input  logic                  in_valid,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CAT_W = BCD_W + BIN_W;
    localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);
    localparam longint unsigned BIN_LIM = (64'd1 << BIN_W) - 64'd1;
    localparam longint unsigned DEC_LIM = 64'(10 ** DIGITS) - 64'd1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_CONV = 1'b1;

    generate
        if (BIN_W < 1 || BIN_W > 16) begin : g_bad_bin_w
            $error("bin2bcd_seq: BIN_W out of range 1..16");
        end
        if (DIGITS < 1 || DIGITS > 5) begin : g_bad_digits
            $error("bin2bcd_seq: DIGITS out of range 1..5");
        end
        if (64'(MAX_VAL) > BIN_LIM || 64'(MAX_VAL) > DEC_LIM) begin : g_bad_max
            $error("bin2bcd_seq: MAX_VAL not representable in BIN_W bits or DIGITS digits");
        end
    endgenerate

    logic [0:0]       state_q,  state_d;
    logic [BIN_W-1:0] shift_q,  shift_d;
    logic [BCD_W-1:0] scr_q,    scr_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             range_q,  range_d;
    logic [BCD_W-1:0] bcd_q,    bcd_d;
    logic             ovf_q,    ovf_d;
    logic             vld_q,    vld_d;

    logic [BCD_W-1:0] adj;
    logic [CAT_W-1:0] cat;
    logic [3:0]       nib;

    always_comb begin
        adj = '0;
        nib = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            nib = scr_q[4*k +: 4];
            adj[4*k +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
        // The top scratch bit falls off here; MAX_VAL bounds keep it zero.
        cat = {adj, shift_q} << 1;
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        range_d = range_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        vld_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_CONV;
                    shift_d = bin_in;
                    scr_d   = '0;
                    cnt_d   = '0;
                    range_d = (32'(bin_in) > MAX_VAL);
                end
            end
            ST_CONV: begin
                scr_d   = cat[CAT_W-1:BIN_W];
                shift_d = cat[BIN_W-1:0];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    vld_d   = 1'b1;
                    ovf_d   = range_q;
                    if (!range_q) begin
                        bcd_d = cat[CAT_W-1:BIN_W];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            range_q <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            range_q <= range_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            vld_q   <= vld_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = vld_q;
    assign bcd       = bcd_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: a 6-bit/2-digit instance and a 10-bit/4-digit instance
// checked against decimal arithmetic.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        reset_;
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;

    logic        a_in_valid, a_in_ready, a_out_valid, a_ovf;
    logic [5:0]  a_bin;
    logic [7:0]  a_bcd;
    logic        b_in_valid, b_in_ready, b_out_valid, b_ovf;
    logic [9:0]  b_bin;
    logic [15:0] b_bcd;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bin2bcd_seq #(.BIN_W(6), .DIGITS(2), .MAX_VAL(59)) u_a (
        .clk(clk), .reset_(reset_), .in_valid(a_in_valid), .bin_in(a_bin),
        .in_ready(a_in_ready), .out_valid(a_out_valid), .bcd(a_bcd), .ovf(a_ovf)
    );

    bin2bcd_seq #(.BIN_W(10), .DIGITS(4), .MAX_VAL(999)) u_b (
        .clk(clk), .reset_(reset_), .in_valid(b_in_valid), .bin_in(b_bin),
        .in_ready(b_in_ready), .out_valid(b_out_valid), .bcd(b_bcd), .ovf(b_ovf)
    );

    typedef struct {
        logic [5:0] bin;
        logic [7:0] bcd;
        logic       ovf;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Decimal digits by division, independent of any shifting scheme.
    function automatic logic [19:0] ref_bcd(input int unsigned v);
        logic [19:0] r;
        int unsigned p;
        r = '0;
        p = 1;
        for (int k = 0; k < 5; k++) begin
            r[4*k +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic wait_a(input string nm, output int t);
        for (int i = 0; i < 30 && !a_out_valid; i++) begin
            @(posedge clk); #1;
        end
        chk({nm, " out_valid seen"}, a_out_valid, 1);
        t = cyc;
    endtask

    task automatic wait_b(input string nm, output int t);
        for (int i = 0; i < 40 && !b_out_valid; i++) begin
            @(posedge clk); #1;
        end
        chk({nm, " out_valid seen"}, b_out_valid, 1);
        t = cyc;
    endtask

    task automatic conv_a(input logic [5:0] v, input logic [7:0] eb, input logic eo,
                          input string nm);
        int t0, t1;
        for (int i = 0; i < 20 && !a_in_ready; i++) begin
            @(posedge clk); #1;
        end
        a_in_valid = 1'b1;
        a_bin      = v;
        @(posedge clk); #1;
        t0 = cyc;
        a_in_valid = 1'b0;
        chk({nm, " busy"}, a_in_ready, 0);
        @(posedge clk); #1;
        wait_a(nm, t1);
        chk({nm, " latency"}, t1 - t0, 6);
        chk({nm, " bcd"}, a_bcd, eb);
        chk({nm, " ovf"}, a_ovf, eo);
        chk({nm, " ready on result"}, a_in_ready, 1);
        @(posedge clk); #1;
        chk({nm, " pulse width"}, a_out_valid, 0);
        chk({nm, " bcd hold"}, a_bcd, eb);
    endtask

    task automatic conv_b(input logic [9:0] v, input logic [15:0] eb, input logic eo,
                          input string nm);
        int t0, t1;
        for (int i = 0; i < 20 && !b_in_ready; i++) begin
            @(posedge clk); #1;
        end
        b_in_valid = 1'b1;
        b_bin      = v;
        @(posedge clk); #1;
        t0 = cyc;
        b_in_valid = 1'b0;
        @(posedge clk); #1;
        wait_b(nm, t1);
        chk({nm, " latency"}, t1 - t0, 10);
        chk({nm, " bcd"}, b_bcd, eb);
        chk({nm, " ovf"}, b_ovf, eo);
    endtask

    initial begin
        int          t0, t1, t2, n;
        logic [7:0]  prev_a;
        logic [15:0] prev_b;
        logic [19:0] r;
        int unsigned v;

        tbl[0] = '{6'd0,  8'h00, 1'b0};
        tbl[1] = '{6'd9,  8'h09, 1'b0};
        tbl[2] = '{6'd10, 8'h10, 1'b0};
        tbl[3] = '{6'd59, 8'h59, 1'b0};
        tbl[4] = '{6'd42, 8'h42, 1'b0};
        tbl[5] = '{6'd60, 8'h42, 1'b1};

        reset_     = 1'b0;
        a_in_valid = 1'b0;
        a_bin      = '0;
        b_in_valid = 1'b0;
        b_bin      = '0;
        #1;
        chk("reset bcd", a_bcd, 0);
        chk("reset out_valid", a_out_valid, 0);
        chk("reset ovf", a_ovf, 0);
        #11 reset_ = 1'b1;
        @(posedge clk); #1;
        chk("ready after reset", a_in_ready, 1);

        for (int i = 0; i < 6; i++) begin
            conv_a(tbl[i].bin, tbl[i].bcd, tbl[i].ovf, $sformatf("tbl%0d", i));
        end

        // in_valid held high; a mid-conversion change must be ignored.
        @(posedge clk); #1;
        a_in_valid = 1'b1;
        a_bin      = 6'd37;
        @(posedge clk); #1;
        t0 = cyc;
        chk("held busy", a_in_ready, 0);
        @(posedge clk); #1;
        a_bin = 6'd38;
        wait_a("held r1", t1);
        chk("held r1 latency", t1 - t0, 6);
        chk("held r1 bcd", a_bcd, 8'h37);
        chk("held r1 ovf", a_ovf, 0);
        chk("held r1 ready", a_in_ready, 1);
        @(posedge clk); #1;
        wait_a("held r2", t2);
        a_in_valid = 1'b0;
        chk("held spacing", t2 - t1, 7);
        chk("held r2 bcd", a_bcd, 8'h38);
        @(posedge clk); #1;
        chk("held r2 pulse width", a_out_valid, 0);

        // Reset in the middle of a conversion aborts it.
        a_in_valid = 1'b1;
        a_bin      = 6'd25;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset_ = 1'b0;
        #1;
        chk("abort bcd", a_bcd, 0);
        chk("abort ovf", a_ovf, 0);
        chk("abort out_valid", a_out_valid, 0);
        chk("abort ready", a_in_ready, 1);
        #2 reset_ = 1'b1;
        n = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (a_out_valid) n++;
        end
        chk("abort no result", n, 0);
        chk("abort bcd after", a_bcd, 0);
        conv_a(6'd25, 8'h25, 1'b0, "fresh25");

        prev_a = 8'h25;
        for (int i = 0; i < 40; i++) begin
            v = $urandom_range(0, 63);
            r = ref_bcd(v);
            if (v <= 59) prev_a = r[7:0];
            conv_a(6'(v), prev_a, (v > 59), $sformatf("randA v=%0d", v));
        end

        conv_b(10'd999, 16'h0999, 1'b0, "b999");
        conv_b(10'd1000, 16'h0999, 1'b1, "b1000");
        prev_b = 16'h0999;
        for (int i = 0; i < 1024; i++) begin
            r = ref_bcd(i);
            if (i <= 999) prev_b = r[15:0];
            conv_b(10'(i), prev_b, (i > 999), $sformatf("sweep v=%0d", i));
        end
        for (int i = 0; i < 100; i++) begin
            v = $urandom_range(0, 1023);
            r = ref_bcd(v);
            if (v <= 999) prev_b = r[15:0];
            conv_b(10'(v), prev_b, (v > 999), $sformatf("randB v=%0d", v));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
